// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and vertical-phase encoding, also used by pixel generators.
package vga_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int DIV_DEF       = 4;
    localparam int CNT_W         = 10;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FRONTP = 2'd1,
        V_SYNCP  = 2'd2,
        V_BACKP  = 2'd3
    } vstate_e;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] last);
        return (v == last) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider producing a one-clk pixel strobe every DIV enabled cycles.
module pixel_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic pixel_tick
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (enable) div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    // Gated by reset so a reset cycle never emits a strobe.
    assign pixel_tick = enable && !reset && (div_q == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters, vertical phase FSM and registered sync/blank outputs.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int DIV       = DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VF_START = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VB_START = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             tick, line_wrap;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    vstate_e          state_q, state_d;
    logic             hsync_q, vsync_q, video_on_q, frame_start_q;

    pixel_tick_gen #(.DIV(DIV)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pixel_tick (tick)
    );

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        state_d   = state_q;
        line_wrap = tick && (x_q == H_LAST);
        if (tick) x_d = wrap_inc(x_q, H_LAST);
        if (line_wrap) begin
            y_d = wrap_inc(y_q, V_LAST);
            if      (y_d == VF_START) state_d = V_FRONTP;
            else if (y_d == VS_START) state_d = V_SYNCP;
            else if (y_d == VB_START) state_d = V_BACKP;
            else if (y_d == '0)       state_d = V_ACTIVE;
        end
    end

    // Outputs are decoded from next-state values so they line up with pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            state_q       <= V_ACTIVE;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            state_q       <= state_d;
            hsync_q       <= !((x_d >= HS_START) && (x_d < HS_END));
            vsync_q       <= (state_d != V_SYNCP);
            video_on_q    <= (x_d < H_VIS) && (state_d == V_ACTIVE);
            frame_start_q <= line_wrap && (y_q == V_LAST);
        end
    end

    assign pixel_tick  = tick;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunken raster so a whole frame fits the cycle budget.
module tb_vga_timing_ctrl;
    localparam int HV = 64, HF = 8, HS = 12, HB = 6;
    localparam int VV = 20, VF = 3, VS = 2, VB = 4;
    localparam int D  = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int HS0 = HV + HF;
    localparam int VS0 = VV + VF;

    logic       clk = 1'b0, reset = 1'b1, enable = 1'b1;
    logic       pixel_tick, hsync, vsync, video_on, frame_start;
    logic [9:0] pixel_x, pixel_y;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .DIV(D)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pixel_tick(pixel_tick),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
    );

    typedef struct { int x; int y; int hs; int vs; int von; int fs; } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0, cyc = 0, fs_seen = 0;
    int mx, my, tick_cyc, last_cyc, c0, tk, vl;
    int hs_run, hs_first, vs_ticks, vs_min, vs_max, fs_tick;
    bit ok;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        cyc++;
        if (frame_start === 1'b1) fs_seen++;
    endtask

    task automatic wait_tick(output bit found);
        found = 1'b0;
        for (int k = 0; k < 2*D + 2; k++) begin
            if (pixel_tick === 1'b1) begin found = 1'b1; break; end
            nstep();
        end
        if (!found) chk("tick_timeout", 0, 1);
    endtask

    function automatic exp_t model_next(input int x, input int y);
        exp_t e;
        e.x   = (x == HT-1) ? 0 : x + 1;
        e.y   = (x == HT-1) ? ((y == VT-1) ? 0 : y + 1) : y;
        e.hs  = (e.x >= HS0 && e.x < HS0 + HS) ? 0 : 1;
        e.vs  = (e.y >= VS0 && e.y < VS0 + VS) ? 0 : 1;
        e.von = (e.x < HV && e.y < VV) ? 1 : 0;
        e.fs  = (x == HT-1 && y == VT-1) ? 1 : 0;
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        chk("sb_x", int'(pixel_x), e.x);
        chk("sb_y", int'(pixel_y), e.y);
        chk("sb_hsync", int'(hsync), e.hs);
        chk("sb_vsync", int'(vsync), e.vs);
        chk("sb_video_on", int'(video_on), e.von);
        chk("sb_frame_start", int'(frame_start), e.fs);
    endtask

    // One pixel step: expectation queued at the tick, compared after the edge that applies it.
    task automatic adv(output bit found);
        exp_t e;
        wait_tick(found);
        if (!found) return;
        tick_cyc = cyc;
        e = model_next(mx, my);
        sb.push_back(e);
        mx = e.x;
        my = e.y;
        nstep();
        pop_check();
    endtask

    task automatic run_to(input int tx, input int ty);
        bit f;
        for (int i = 0; i < HT*VT + 1 && !(mx == tx && my == ty); i++) begin
            adv(f);
            if (!f) break;
        end
        chk("run_to_reached", (mx == tx && my == ty) ? 1 : 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; tk = 0;
        repeat (3*D) begin
            nstep();
            if (pixel_tick === 1'b1) tk++;
        end
        chk("rst_beats_enable_no_tick", tk, 0);
        chk("rst_x", int'(pixel_x), 0);
        chk("rst_y", int'(pixel_y), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_video_on", int'(video_on), 1);
        chk("rst_frame_start", int'(frame_start), 0);

        reset = 1'b0; mx = 0; my = 0; fs_seen = 0;
        c0 = cyc;
        wait_tick(ok);
        chk("first_tick_latency", cyc - c0, D - 1);

        hs_run = 0; hs_first = -1; vs_ticks = 0; vs_min = 9999; vs_max = -1; fs_tick = -1;
        last_cyc = 0;
        for (int t = 0; t < HT*VT; t++) begin
            adv(ok);
            if (!ok) break;
            if (t > 0 && t <= 16) chk("tick_period", tick_cyc - last_cyc, D);
            last_cyc = tick_cyc;
            if (my == 0 && hsync === 1'b0) begin
                if (hs_run == 0) hs_first = int'(pixel_x);
                hs_run++;
            end
            if (vsync === 1'b0) begin
                vs_ticks++;
                if (int'(pixel_y) < vs_min) vs_min = int'(pixel_y);
                if (int'(pixel_y) > vs_max) vs_max = int'(pixel_y);
            end
            if (mx == HV-1 && my == VV-1) chk("von_last_visible", int'(video_on), 1);
            if (mx == HV   && my == VV-1) chk("von_right_edge", int'(video_on), 0);
            if (mx == 0    && my == VV)   chk("von_bottom_edge", int'(video_on), 0);
            if (frame_start === 1'b1) fs_tick = t + 1;
        end
        chk("hsync_low_ticks_line0", hs_run, HS);
        chk("hsync_low_start_x", hs_first, HS0);
        chk("vsync_low_first_y", vs_min, VS0);
        chk("vsync_low_last_y", vs_max, VS0 + VS - 1);
        chk("vsync_low_ticks", vs_ticks, VS * HT);
        chk("frame_start_pulses", fs_seen, 1);
        chk("frame_start_tick", fs_tick, HT * VT);

        run_to(HS0 + 3, 10);
        enable = 1'b0;
        repeat (10) begin
            nstep();
            chk("frz_x", int'(pixel_x), HS0 + 3);
            chk("frz_y", int'(pixel_y), 10);
            chk("frz_hsync", int'(hsync), 0);
            chk("frz_vsync", int'(vsync), 1);
            chk("frz_video_on", int'(video_on), 0);
            chk("frz_tick", int'(pixel_tick), 0);
            chk("frz_frame_start", int'(frame_start), 0);
        end
        enable = 1'b1;
        repeat (D - 1) nstep();
        chk("resume_hold_x", int'(pixel_x), HS0 + 3);
        nstep();
        chk("resume_next_x", int'(pixel_x), HS0 + 4);
        mx = HS0 + 4; my = 10;

        run_to(HS0 - 1, VS0 + VS - 1);
        chk("pre_rst_vsync", int'(vsync), 0);
        chk("pre_rst_hsync", int'(hsync), 1);
        reset = 1'b1;
        nstep();
        chk("mid_rst_x", int'(pixel_x), 0);
        chk("mid_rst_y", int'(pixel_y), 0);
        chk("mid_rst_hsync", int'(hsync), 1);
        chk("mid_rst_vsync", int'(vsync), 1);
        chk("mid_rst_video_on", int'(video_on), 1);
        chk("mid_rst_frame_start", int'(frame_start), 0);
        reset = 1'b0; vl = 0;
        repeat (D) begin
            nstep();
            if (vsync !== 1'b1 || hsync !== 1'b1) vl++;
        end
        chk("post_rst_no_sync", vl, 0);
        chk("post_rst_x", int'(pixel_x), 1);
        chk("post_rst_y", int'(pixel_y), 0);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
